mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 210 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: SPARC memory-access stage with one outstanding 64-bit big-endian bus transfer.
// Optional feature macro MEM_DOUBLE_EN enables LDD/STD; without it they raise wb_exc.
module mem_stage #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ex_ready,
  input  logic [31:0]               ex_alures,
  input  logic [1:0]                ex_op,
  input  logic [5:0]                ex_op3,
  input  logic [4:0]                ex_regD,
  input  logic [BUS_DATA_WIDTH-1:0] ex_valD,
  input  logic                      ex_regWrite,
  input  logic                      ex_regWriteDouble,
  output logic                      mem_ready,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [ADDR_WIDTH-1:0]     dmem_addr,
  output logic [BUS_DATA_WIDTH-1:0] dmem_wdata,
  output logic [7:0]                dmem_be,
  input  logic                      dmem_ack,
  input  logic [BUS_DATA_WIDTH-1:0] dmem_rdata,
  output logic                      wb_valid,
  output logic [4:0]                wb_rd,
  output logic [BUS_DATA_WIDTH-1:0] wb_data,
  output logic                      wb_regWrite,
  output logic                      wb_regWriteDouble,
  output logic                      wb_exc
);

`ifdef MEM_DOUBLE_EN
  localparam bit DBL_EN = 1'b1;
`else
  localparam bit DBL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;
  typedef enum logic {IDLE, BUSY} state_t;

  // Shifting left by the byte offset brings the addressed byte to bits [63:56].
  function automatic logic [63:0] f_load_lane(input logic [63:0] rdata, input size_t sz,
                                              input logic [2:0] off, input logic sgn);
    logic [63:0] sh;
    logic [31:0] v;
    sh = rdata << {off, 3'b000};
    case (sz)
      SZ_B:    v = {{24{sgn & sh[63]}}, sh[63:56]};
      SZ_H:    v = {{16{sgn & sh[63]}}, sh[63:48]};
      SZ_W:    v = sh[63:32];
      default: v = '0;
    endcase
    return (sz == SZ_D) ? rdata : {32'b0, v};
  endfunction

  function automatic logic [7:0] f_store_be(input size_t sz, input logic [2:0] off);
    case (sz)
      SZ_B:    return 8'h80 >> off;
      SZ_H:    return 8'hC0 >> off;
      SZ_W:    return 8'hF0 >> off;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] f_store_data(input size_t sz, input logic [63:0] val);
    case (sz)
      SZ_B:    return {8{val[7:0]}};
      SZ_H:    return {4{val[15:0]}};
      SZ_W:    return {2{val[31:0]}};
      default: return val;
    endcase
  endfunction

  state_t r_state, w_state_nxt;
  logic   w_is_mem, w_is_load, w_sgn, w_misalign, w_idle_take, w_exc, w_start;
  size_t  w_size;

  always_comb begin
    w_is_mem  = 1'b0;
    w_is_load = 1'b0;
    w_sgn     = 1'b0;
    w_size    = SZ_W;
    if (ex_op == 2'b11) begin
      w_is_mem = 1'b1;
      case (ex_op3)
        6'b000000: w_is_load = 1'b1;
        6'b000001: begin w_is_load = 1'b1; w_size = SZ_B; end
        6'b000010: begin w_is_load = 1'b1; w_size = SZ_H; end
        6'b000011: begin w_is_load = 1'b1; w_size = SZ_D; end
        6'b000100: w_size = SZ_W;
        6'b000101: w_size = SZ_B;
        6'b000110: w_size = SZ_H;
        6'b000111: w_size = SZ_D;
        6'b001001: begin w_is_load = 1'b1; w_sgn = 1'b1; w_size = SZ_B; end
        6'b001010: begin w_is_load = 1'b1; w_sgn = 1'b1; w_size = SZ_H; end
        default:   w_is_mem = 1'b0;
      endcase
    end
    case (w_size)
      SZ_H:    w_misalign = ex_alures[0];
      SZ_W:    w_misalign = |ex_alures[1:0];
      SZ_D:    w_misalign = (|ex_alures[2:0]) | ~DBL_EN;
      default: w_misalign = 1'b0;
    endcase
    w_idle_take = ex_ready & (r_state == IDLE);
    w_exc       = w_idle_take & w_is_mem & w_misalign;
    w_start     = w_idle_take & w_is_mem & ~w_misalign;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        mem_ready = 1'b1;
        if (w_start) w_state_nxt = BUSY;
      end
      BUSY:    if (dmem_ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Transfer context captured at accept, consumed when the ack returns.
  logic [2:0] r_off_p0;
  size_t      r_size_p0;
  logic       r_sgn_p0, r_load_p0, r_rw_p0;
  logic [4:0] r_rd_p0;

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_off_p0  <= ex_alures[2:0];
      r_size_p0 <= w_size;
      r_sgn_p0  <= w_sgn;
      r_load_p0 <= w_is_load;
      r_rw_p0   <= ex_regWrite & w_is_load;
      r_rd_p0   <= ex_regD;
    end
  end

  logic                      r_req, r_we, r_wb_valid, r_wb_exc, r_wb_rw, r_wb_rwd;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [BUS_DATA_WIDTH-1:0] r_wdata, r_wb_data;
  logic [7:0]                r_be;
  logic [4:0]                r_wb_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_wb_valid <= 1'b0;
      r_wb_exc   <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_rw    <= 1'b0;
      r_wb_rwd   <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_exc   <= 1'b0;
      if (w_exc) begin
        r_wb_valid <= 1'b1;
        r_wb_exc   <= 1'b1;
        r_wb_rd    <= ex_regD;
        r_wb_rw    <= 1'b0;
        r_wb_rwd   <= 1'b0;
      end else if (w_idle_take && !w_is_mem) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= {32'b0, ex_alures};
        r_wb_rd    <= ex_regD;
        r_wb_rw    <= ex_regWrite;
        r_wb_rwd   <= ex_regWriteDouble;
      end else if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= ~w_is_load;
        r_addr  <= ADDR_WIDTH'({ex_alures[31:3], 3'b000});
        r_be    <= f_store_be(w_size, ex_alures[2:0]);
        r_wdata <= f_store_data(w_size, ex_valD);
      end else if (r_state == BUSY && dmem_ack) begin
        r_req      <= 1'b0;
        r_we       <= 1'b0;
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd_p0;
        r_wb_rw    <= r_rw_p0;
        r_wb_rwd   <= r_load_p0 && (r_size_p0 == SZ_D);
        if (r_load_p0) r_wb_data <= f_load_lane(dmem_rdata, r_size_p0, r_off_p0, r_sgn_p0);
      end
    end
  end

  assign dmem_req          = r_req;
  assign dmem_we           = r_we;
  assign dmem_addr         = r_addr;
  assign dmem_wdata        = r_wdata;
  assign dmem_be           = r_be;
  assign wb_valid          = r_wb_valid;
  assign wb_exc            = r_wb_exc;
  assign wb_rd             = r_wb_rd;
  assign wb_data           = r_wb_data;
  assign wb_regWrite       = r_wb_rw;
  assign wb_regWriteDouble = DBL_EN & r_wb_rwd;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table vectors, hand sequences and randomized traffic against a byte-level model.
`timescale 1ns/1ps
module tb_mem_stage;

`ifdef MEM_DOUBLE_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif
  localparam int K_ALU = 0, K_EXC = 1, K_LD = 2, K_ST = 3;

  logic        clk = 1'b0;
  logic        reset, ex_ready, ex_regWrite, ex_regWriteDouble, dmem_ack;
  logic [31:0] ex_alures;
  logic [1:0]  ex_op;
  logic [5:0]  ex_op3;
  logic [4:0]  ex_regD;
  logic [63:0] ex_valD, dmem_rdata;
  logic        mem_ready, dmem_req, dmem_we, wb_valid, wb_regWrite, wb_regWriteDouble, wb_exc;
  logic [31:0] dmem_addr;
  logic [63:0] dmem_wdata, wb_data;
  logic [7:0]  dmem_be;
  logic [4:0]  wb_rd;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .ex_ready(ex_ready), .ex_alures(ex_alures), .ex_op(ex_op),
    .ex_op3(ex_op3), .ex_regD(ex_regD), .ex_valD(ex_valD), .ex_regWrite(ex_regWrite),
    .ex_regWriteDouble(ex_regWriteDouble), .mem_ready(mem_ready), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_regWrite(wb_regWrite), .wb_regWriteDouble(wb_regWriteDouble),
    .wb_exc(wb_exc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: decode op3 into byte count, then build results byte by byte.
  task automatic model(input logic [1:0] op, input logic [5:0] op3, input logic [31:0] addr,
                       input logic [63:0] vald, input logic [63:0] rdata,
                       output int kind, output logic [63:0] e_data, output logic [7:0] e_be,
                       output logic [63:0] e_wm, output logic e_rwd);
    int n, off;
    bit ld, sg;
    logic [63:0] v;
    logic [7:0]  b;
    n = 0; ld = 0; sg = 0;
    kind = K_ALU; e_data = {32'b0, addr}; e_be = '0; e_wm = '0; e_rwd = 1'b0;
    if (op == 2'b11) begin
      case (op3)
        6'o00: begin n = 4; ld = 1; end
        6'o01: begin n = 1; ld = 1; end
        6'o02: begin n = 2; ld = 1; end
        6'o03: begin n = 8; ld = 1; end
        6'o04: n = 4;
        6'o05: n = 1;
        6'o06: n = 2;
        6'o07: n = 8;
        6'o11: begin n = 1; ld = 1; sg = 1; end
        6'o12: begin n = 2; ld = 1; sg = 1; end
        default: n = 0;
      endcase
    end
    if (n == 0) return;
    off = int'(addr[2:0]);
    if ((off % n) != 0 || (n == 8 && !DBL)) begin
      kind = K_EXC;
      return;
    end
    if (ld) begin
      kind = K_LD;
      v = '0;
      for (int i = 0; i < n; i++) begin
        b = rdata[63-8*(off+i) -: 8];
        v = (v << 8) | 64'(b);
      end
      if (sg && rdata[63-8*off]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      e_data = (n == 8) ? v : {32'b0, v[31:0]};
      e_rwd  = (n == 8);
    end else begin
      kind = K_ST;
      for (int i = 0; i < n; i++) begin
        e_be[7-(off+i)] = 1'b1;
        e_wm[63-8*(off+i) -: 8] = vald[8*(n-1-i) +: 8];
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] op3, input logic [31:0] addr,
                       input logic [63:0] vald, input logic [63:0] rdata, input int wait_n,
                       input int kind, input logic [63:0] e_data, input logic [7:0] e_be,
                       input logic [63:0] e_wm, input logic e_rwd);
    logic [63:0] bm, w0;
    logic [31:0] a0;
    logic [7:0]  b0;
    logic [4:0]  rd;
    logic        held;
    int          busy;
    rd = 5'($urandom);
    chk("ready_before", 64'(mem_ready), 64'd1);
    ex_ready = 1; ex_op = op; ex_op3 = op3; ex_alures = addr; ex_valD = vald;
    ex_regD = rd; ex_regWrite = 1; ex_regWriteDouble = 0;
    tick;
    ex_ready = 0; ex_op = 2'($urandom); ex_alures = $urandom;
    if (kind == K_EXC) begin
      chk("exc_pulse", 64'({wb_valid, wb_exc, wb_regWrite, dmem_req, mem_ready}), 64'b11001);
      tick;
      chk("exc_clear", 64'({wb_valid, wb_exc}), 64'd0);
    end else if (kind == K_ALU) begin
      chk("alu_wb", 64'({wb_valid, wb_exc, mem_ready, dmem_req}), 64'b1010);
      chk("alu_data", wb_data, e_data);
      chk("alu_rd", 64'(wb_rd), 64'(rd));
      tick;
      chk("alu_clear", 64'(wb_valid), 64'd0);
    end else begin
      chk("req", 64'({dmem_req, mem_ready, dmem_we}), 64'({2'b10, kind == K_ST}));
      chk("addr", 64'(dmem_addr), 64'({addr[31:3], 3'b000}));
      if (kind == K_ST) begin
        chk("be", 64'(dmem_be), 64'(e_be));
        for (int i = 0; i < 8; i++) bm[63-8*i -: 8] = {8{e_be[7-i]}};
        chk("wdata", dmem_wdata & bm, e_wm);
      end
      a0 = dmem_addr; w0 = dmem_wdata; b0 = dmem_be;
      held = 1'b1;
      busy = mem_ready ? 0 : 1;
      for (int i = 0; i < wait_n; i++) begin
        tick;
        if (!mem_ready) busy++;
        held = held & dmem_req & (dmem_addr == a0) & (dmem_wdata == w0) & (dmem_be == b0) & ~wb_valid;
      end
      chk("hold", 64'(held), 64'd1);
      dmem_ack = 1; dmem_rdata = rdata;
      tick;
      dmem_ack = 0; dmem_rdata = {$urandom, $urandom};
      chk("busy_cycles", 64'(busy), 64'(wait_n + 1));
      chk("done", 64'({wb_valid, wb_exc, mem_ready, dmem_req}), 64'b1010);
      chk("wb_rw", 64'({wb_regWrite, wb_regWriteDouble}), 64'({kind == K_LD, e_rwd}));
      chk("wb_rd", 64'(wb_rd), 64'(rd));
      if (kind == K_LD) chk("ld_data", wb_data, e_data);
      tick;
      chk("done_clear", 64'(wb_valid), 64'd0);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  op3;
    logic [31:0] addr;
    logic [63:0] vald;
    logic [63:0] rdata;
    int          wait_n;
    int          kind;
    logic [63:0] e_data;
    logic [7:0]  e_be;
    logic [63:0] e_wm;
    logic        e_rwd;
  } vec_t;

  vec_t tbl[11];
  logic [5:0] ops[10] = '{6'o00, 6'o01, 6'o02, 6'o03, 6'o04, 6'o05, 6'o06, 6'o07, 6'o11, 6'o12};

  initial begin
    int kind;
    logic [63:0] e_data, e_wm, vald, rdata;
    logic [7:0]  e_be;
    logic        e_rwd;
    logic [1:0]  op;
    logic [5:0]  op3;
    logic [31:0] addr;

    tbl[0]  = '{2'b10, 6'o00, 32'h0000_1234, 64'd0, 64'd0, 0, K_ALU, 64'h1234, 8'h00, 64'd0, 1'b0};
    tbl[1]  = '{2'b11, 6'o11, 32'h0000_1003, 64'd0, 64'h0000_0080_0000_0000, 3, K_LD,
                64'h0000_0000_FFFF_FF80, 8'h00, 64'd0, 1'b0};
    tbl[2]  = '{2'b11, 6'o06, 32'h0000_2006, 64'h0000_0000_0000_BEEF, 64'd0, 1, K_ST, 64'd0,
                8'h03, 64'h0000_0000_0000_BEEF, 1'b0};
    tbl[3]  = '{2'b11, 6'o00, 32'h0000_2002, 64'd0, 64'd0, 0, K_EXC, 64'd0, 8'h00, 64'd0, 1'b0};
    tbl[4]  = DBL ? '{2'b11, 6'o03, 32'h0000_3000, 64'd0, 64'hAABB_CCDD_1122_3344, 0, K_LD,
                      64'hAABB_CCDD_1122_3344, 8'h00, 64'd0, 1'b1}
                  : '{2'b11, 6'o03, 32'h0000_3000, 64'd0, 64'hAABB_CCDD_1122_3344, 0, K_EXC,
                      64'd0, 8'h00, 64'd0, 1'b0};
    tbl[5]  = '{2'b11, 6'o02, 32'h0000_4002, 64'd0, 64'h0011_8899_2233_4455, 0, K_LD,
                64'h0000_0000_0000_8899, 8'h00, 64'd0, 1'b0};
    tbl[6]  = '{2'b11, 6'o12, 32'h0000_4002, 64'd0, 64'h0011_8899_2233_4455, 2, K_LD,
                64'h0000_0000_FFFF_8899, 8'h00, 64'd0, 1'b0};
    tbl[7]  = '{2'b11, 6'o00, 32'h0000_5004, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 1, K_LD,
                64'h0000_0000_CAFE_F00D, 8'h00, 64'd0, 1'b0};
    tbl[8]  = '{2'b11, 6'o05, 32'h0000_6005, 64'h0000_0000_0000_005A, 64'd0, 0, K_ST, 64'd0,
                8'h04, 64'h0000_0000_005A_0000, 1'b0};
    tbl[9]  = '{2'b11, 6'o04, 32'h0000_7000, 64'h0000_0000_1234_5678, 64'd0, 0, K_ST, 64'd0,
                8'hF0, 64'h1234_5678_0000_0000, 1'b0};
    tbl[10] = '{2'b11, 6'o17, 32'h0000_ABCD, 64'd0, 64'd0, 0, K_ALU, 64'h0000_ABCD, 8'h00,
                64'd0, 1'b0};

    reset = 1; ex_ready = 0; ex_op = 0; ex_op3 = 0; ex_alures = 0; ex_regD = 0; ex_valD = 0;
    ex_regWrite = 0; ex_regWriteDouble = 0; dmem_ack = 0; dmem_rdata = 0;
    tick; tick;
    chk("rst_ctrl", 64'({mem_ready, dmem_req, dmem_we, wb_valid, wb_exc, wb_regWrite,
                         wb_regWriteDouble}), 64'b1000000);
    chk("rst_addr", 64'(dmem_addr), 64'd0);
    chk("rst_wdata", dmem_wdata, 64'd0);
    chk("rst_be", 64'(dmem_be), 64'd0);
    chk("rst_wbdata", wb_data, 64'd0);
    chk("rst_wbrd", 64'(wb_rd), 64'd0);
    reset = 0;
    tick;

    for (int i = 0; i < 11; i++)
      issue(tbl[i].op, tbl[i].op3, tbl[i].addr, tbl[i].vald, tbl[i].rdata, tbl[i].wait_n,
            tbl[i].kind, tbl[i].e_data, tbl[i].e_be, tbl[i].e_wm, tbl[i].e_rwd);

    // Ack and a new request in the same cycle: the new one waits a cycle.
    ex_ready = 1; ex_op = 2'b11; ex_op3 = 6'o00; ex_alures = 32'h9000; ex_regWrite = 1;
    tick;
    ex_op = 2'b10; ex_alures = 32'h55;
    dmem_ack = 1; dmem_rdata = 64'h1111_2222_3333_4444;
    chk("ack_cycle_busy", 64'(mem_ready), 64'd0);
    tick;
    dmem_ack = 0;
    chk("ack_overlap_ld", 64'({wb_valid, mem_ready}), 64'b11);
    chk("ack_overlap_data", wb_data, 64'h1111_2222);
    tick;
    ex_ready = 0;
    chk("overlap_accept", 64'({wb_valid, wb_data[31:0]}), 64'({1'b1, 32'h55}));
    tick;
    chk("overlap_clear", 64'(wb_valid), 64'd0);

    // Reset while BUSY abandons the transfer; a late ack is ignored.
    ex_ready = 1; ex_op = 2'b11; ex_op3 = 6'o00; ex_alures = 32'h8000;
    tick;
    ex_ready = 0;
    chk("rb_req", 64'(dmem_req), 64'd1);
    tick;
    reset = 1;
    tick;
    reset = 0;
    chk("rb_drop", 64'({dmem_req, wb_valid, mem_ready}), 64'b001);
    dmem_ack = 1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    dmem_ack = 0;
    chk("rb_late_ack", 64'({dmem_req, wb_valid, mem_ready}), 64'b001);
    tick;
    chk("rb_quiet", 64'({wb_valid, wb_exc}), 64'd0);

    for (int i = 0; i < 60; i++) begin
      op    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      op3   = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      addr  = $urandom;
      vald  = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      model(op, op3, addr, vald, rdata, kind, e_data, e_be, e_wm, e_rwd);
      issue(op, op3, addr, vald, rdata, $urandom_range(0, 3), kind, e_data, e_be, e_wm, e_rwd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
